// File: rtl/matvec_n_pkg.sv
// Shared types and helpers for the streaming matrix-vector multiplier.
package matvec_n_pkg;

  // Control FSM states of matvec_n.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_X  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

  // Full-precision result width: a DW x DW product needs 2*DW bits and
  // summing n of them adds clog2(n) bits of headroom.
  function automatic int out_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matvec_n_mac.sv
// Multiply-accumulate slice for one result row: one product register stage
// followed by a full-precision accumulator.
module matvec_n_mac #(
  parameter int DW = 14,
  parameter int OW = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 mul_en,
  input  logic                 acc_en,
  input  logic signed [DW-1:0] w_op,
  input  logic signed [DW-1:0] x_op,
  output logic signed [OW-1:0] acc
);

  logic signed [2*DW-1:0] w_ext_s;
  logic signed [2*DW-1:0] x_ext_s;
  logic signed [2*DW-1:0] prod_s;
  logic signed [2*DW-1:0] prod_r;
  logic signed [OW-1:0]   prod_ext_s;
  logic signed [OW-1:0]   acc_r;

  // Sign-extend operands so the truncated 2*DW product is exact.
  always_comb begin
    w_ext_s    = {{DW{w_op[DW-1]}}, w_op};
    x_ext_s    = {{DW{x_op[DW-1]}}, x_op};
    prod_s     = w_ext_s * x_ext_s;
    prod_ext_s = {{(OW-2*DW){prod_r[2*DW-1]}}, prod_r};
  end

  // Product pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_r <= {(2*DW){1'b0}};
    end else if (mul_en) begin
      prod_r <= prod_s;
    end
  end

  // Accumulator: clear at row start, then add each registered product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= {OW{1'b0}};
    end else if (clr) begin
      acc_r <= {OW{1'b0}};
    end else if (acc_en) begin
      acc_r <= acc_r + prod_ext_s;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/matvec_n.sv
// Streaming NxN matrix times N-vector multiplier. A packet is either a full
// matrix followed by a vector, or a vector alone that reuses the stored
// matrix. Results y[0..N-1] are streamed out one row at a time.
// Optional feature macro: MATVEC_N_RELU_EN clamps negative results to zero.
module matvec_n
  import matvec_n_pkg::*;
#(
  parameter int  N  = 8,
  parameter int  DW = 14,
  localparam int OW = out_width(DW, N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  input  logic [DW-1:0] input_data,
  input  logic          new_matrix,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [OW-1:0] output_data
);

  localparam int WIW = $clog2(N * N);
  localparam int XIW = $clog2(N);
  localparam int KW  = $clog2(N + 2);

  state_t state_r;
  state_t state_nx_s;

  logic [WIW-1:0] w_idx_r;
  logic [XIW-1:0] x_idx_r;
  logic [XIW-1:0] row_r;
  logic [KW-1:0]  k_r;
  logic           matrix_loaded_r;
  logic           output_valid_r;
  logic [OW-1:0]  output_data_r;

  logic signed [DW-1:0] w_mem_r [N*N];
  logic signed [DW-1:0] x_r     [N];

  logic           accept_s;
  logic           out_xfer_s;
  logic           w_last_s;
  logic           x_last_s;
  logic           k_done_s;
  logic           row_last_s;
  logic           w_we_s;
  logic           x_we_s;
  logic [WIW-1:0] w_waddr_s;
  logic [XIW-1:0] x_waddr_s;
  logic           mac_clr_s;
  logic           mac_mul_s;
  logic           mac_acc_s;
  logic [XIW-1:0] col_s;
  logic [WIW-1:0] rd_addr_s;
  logic signed [DW-1:0] w_op_s;
  logic signed [DW-1:0] x_op_s;
  logic signed [OW-1:0] acc_s;
  logic [OW-1:0]  result_s;

  // Input is open in the load states only, and held closed during reset.
  assign input_ready = reset && ((state_r == ST_IDLE) || (state_r == ST_LOAD_W) ||
                                 (state_r == ST_LOAD_X));
  assign accept_s    = input_valid && input_ready;
  assign out_xfer_s  = output_valid_r && output_ready;
  assign w_last_s    = (w_idx_r == WIW'(N * N - 1));
  assign x_last_s    = (x_idx_r == XIW'(N - 1));
  assign k_done_s    = (k_r == KW'(N + 1));
  assign row_last_s  = (row_r == XIW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic plus storage write strobes and MAC sequencing.
  // COMPUTE step k: k==0 clears the accumulator, k<N issues product c=k,
  // 1<=k<=N accumulates product k-1, k==N+1 latches the finished row.
  always_comb begin
    state_nx_s = state_r;
    w_we_s     = 1'b0;
    x_we_s     = 1'b0;
    w_waddr_s  = w_idx_r;
    x_waddr_s  = x_idx_r;
    mac_clr_s  = 1'b0;
    mac_mul_s  = 1'b0;
    mac_acc_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (new_matrix) begin
            w_we_s     = 1'b1;
            w_waddr_s  = {WIW{1'b0}};
            state_nx_s = ST_LOAD_W;
          end else begin
            x_we_s     = 1'b1;
            x_waddr_s  = {XIW{1'b0}};
            state_nx_s = ST_LOAD_X;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (accept_s) begin
          w_we_s = 1'b1;
          if (w_last_s) begin
            state_nx_s = ST_LOAD_X;
          end else begin
            state_nx_s = ST_LOAD_W;
          end
        end else begin
          state_nx_s = ST_LOAD_W;
        end
      end
      ST_LOAD_X: begin
        if (accept_s) begin
          x_we_s = 1'b1;
          if (x_last_s) begin
            state_nx_s = ST_COMPUTE;
          end else begin
            state_nx_s = ST_LOAD_X;
          end
        end else begin
          state_nx_s = ST_LOAD_X;
        end
      end
      ST_COMPUTE: begin
        mac_clr_s = (k_r == {KW{1'b0}});
        mac_mul_s = (k_r < KW'(N));
        mac_acc_s = (k_r != {KW{1'b0}}) && (k_r <= KW'(N));
        if (k_done_s) begin
          state_nx_s = ST_OUTPUT;
        end else begin
          state_nx_s = ST_COMPUTE;
        end
      end
      ST_OUTPUT: begin
        if (out_xfer_s) begin
          if (row_last_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_COMPUTE;
          end
        end else begin
          state_nx_s = ST_OUTPUT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Counters, matrix-valid flag and the registered result interface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_idx_r         <= {WIW{1'b0}};
      x_idx_r         <= {XIW{1'b0}};
      row_r           <= {XIW{1'b0}};
      k_r             <= {KW{1'b0}};
      matrix_loaded_r <= 1'b0;
      output_valid_r  <= 1'b0;
      output_data_r   <= {OW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          row_r <= {XIW{1'b0}};
          k_r   <= {KW{1'b0}};
          if (accept_s) begin
            if (new_matrix) begin
              w_idx_r <= WIW'(1);
            end else begin
              x_idx_r <= XIW'(1);
            end
          end
        end
        ST_LOAD_W: begin
          if (accept_s) begin
            w_idx_r <= w_idx_r + WIW'(1);
            if (w_last_s) begin
              matrix_loaded_r <= 1'b1;
              x_idx_r         <= {XIW{1'b0}};
            end
          end
        end
        ST_LOAD_X: begin
          if (accept_s) begin
            x_idx_r <= x_idx_r + XIW'(1);
            if (x_last_s) begin
              k_r   <= {KW{1'b0}};
              row_r <= {XIW{1'b0}};
            end
          end
        end
        ST_COMPUTE: begin
          if (k_done_s) begin
            output_valid_r <= 1'b1;
            output_data_r  <= result_s;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        ST_OUTPUT: begin
          if (out_xfer_s) begin
            output_valid_r <= 1'b0;
            k_r            <= {KW{1'b0}};
            row_r          <= row_r + XIW'(1);
          end
        end
        default: begin
          output_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Element storage; contents survive reset, the valid flag guards use.
  always_ff @(posedge clk) begin
    if (w_we_s) begin
      w_mem_r[w_waddr_s] <= input_data;
    end
    if (x_we_s) begin
      x_r[x_waddr_s] <= input_data;
    end
  end

  // Operand fetch for W[row][k] * x[k]; an unloaded matrix reads as zero.
  always_comb begin
    col_s     = k_r[XIW-1:0];
    rd_addr_s = WIW'(row_r) * WIW'(N) + WIW'(col_s);
    x_op_s    = x_r[col_s];
    if (matrix_loaded_r) begin
      w_op_s = w_mem_r[rd_addr_s];
    end else begin
      w_op_s = {DW{1'b0}};
    end
  end

  matvec_n_mac #(
    .DW(DW),
    .OW(OW)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr_s),
    .mul_en (mac_mul_s),
    .acc_en (mac_acc_s),
    .w_op   (w_op_s),
    .x_op   (x_op_s),
    .acc    (acc_s)
  );

  // Result shaping before it is latched into the output register.
  always_comb begin
    result_s = acc_s;
`ifdef MATVEC_N_RELU_EN
    if (acc_s[OW-1]) begin
      result_s = {OW{1'b0}};
    end else begin
      result_s = acc_s;
    end
`endif
  end

  assign output_valid = output_valid_r;
  assign output_data  = output_data_r;

endmodule

// File: tb/tb_matvec_n.sv
// Directed and randomized-handshake bench for matvec_n with N=4, DW=14.
module tb_matvec_n;

  localparam int N  = 4;
  localparam int DW = 14;
  localparam int OW = 30;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 input_valid = 1'b0;
  logic                 input_ready;
  logic [DW-1:0]        input_data = '0;
  logic                 new_matrix = 1'b0;
  logic                 output_valid;
  logic                 output_ready = 1'b0;
  logic signed [OW-1:0] output_data;

  int total = 0;
  int bad   = 0;
  int w_m [N*N];
  int x_m [N];
  bit loaded_m = 1'b0;

  matvec_n #(.N(N), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .new_matrix   (new_matrix),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic longint exp_out(input longint v);
`ifdef MATVEC_N_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic longint ref_y(input int r);
    longint s = 0;
    if (!loaded_m) return 0;
    for (int c = 0; c < N; c++) s += longint'(w_m[r*N+c]) * longint'(x_m[c]);
    return exp_out(s);
  endfunction

  // Offer one beat with random idle gaps; returns on the accepting edge.
  task automatic send_beat(input int d, input logic nm, input int pct);
    int n = 0;
    @(negedge clk);
    while (($urandom_range(99) >= pct) && (n < 50)) begin
      input_valid = 1'b0;
      input_data  = DW'($urandom);
      @(negedge clk);
      n++;
    end
    input_valid = 1'b1;
    input_data  = d[DW-1:0];
    new_matrix  = nm;
    n = 0;
    while (!input_ready && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (!input_ready) fail_timeout("send_ready");
    @(posedge clk);
  endtask

  task automatic end_pkt();
    @(negedge clk);
    input_valid  = 1'b0;
    new_matrix   = 1'b0;
    output_ready = 1'b0;
  endtask

  task automatic send_mat(input int pct);
    for (int i = 0; i < N*N; i++) send_beat(w_m[i], (i == 0), pct);
    for (int i = 0; i < N; i++) send_beat(x_m[i], ($urandom_range(1) == 1), pct);
    end_pkt();
    loaded_m = 1'b1;
  endtask

  task automatic send_vec(input int pct);
    for (int i = 0; i < N; i++)
      send_beat(x_m[i], (i == 0) ? 1'b0 : ($urandom_range(1) == 1), pct);
    end_pkt();
  endtask

  // Wait for one result, checking hold-while-stalled and input back-pressure.
  task automatic recv(input longint exp, input int pct, input string tag);
    bit     seen = 1'b0;
    bit     done = 1'b0;
    longint hold = 0;
    int     n = 0;
    while (!done && (n < 100)) begin
      @(negedge clk);
      n++;
      output_ready = ($urandom_range(99) < pct);
      check({tag, "_in_ready"}, input_ready, 0);
      if (output_valid) begin
        if (seen) check({tag, "_hold"}, output_data, hold);
        else begin
          seen = 1'b1;
          hold = output_data;
        end
        if (output_ready) begin
          check(tag, output_data, exp);
          done = 1'b1;
        end
      end
    end
    if (!done) fail_timeout({tag, "_valid"});
  endtask

  task automatic recv_model(input int pct, input string tag);
    for (int r = 0; r < N; r++) recv(ref_y(r), pct, $sformatf("%s_y%0d", tag, r));
  endtask

  task automatic set_x(input int a, input int b, input int c, input int d);
    x_m[0] = a; x_m[1] = b; x_m[2] = c; x_m[3] = d;
  endtask

  initial begin
    int cyc;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", input_ready, 0);
    check("rst_out_valid", output_valid, 0);
    check("rst_out_data", output_data, 0);
    reset = 1'b1;
    #1 check("post_rst_in_ready", input_ready, 1);

    // Vector-only with no matrix loaded yields zeros.
    set_x(1, 1, 1, 1);
    send_vec(100);
    for (int r = 0; r < N; r++) recv(0, 100, $sformatf("nomat_y%0d", r));

    // Identity matrix, with result latency from COMPUTE entry.
    for (int i = 0; i < N*N; i++) w_m[i] = ((i / N) == (i % N)) ? 1 : 0;
    set_x(1, -2, 3, -4);
    send_mat(100);
    cyc = 0;
    while (cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
      if (output_valid) break;
    end
    if (!output_valid) fail_timeout("latency");
    else check("latency", cyc, 6);
    recv(exp_out(1), 100, "id_y0");
    recv(exp_out(-2), 100, "id_y1");
    recv(exp_out(3), 100, "id_y2");
    recv(exp_out(-4), 100, "id_y3");

    // Vector-only reuses the identity matrix.
    set_x(1, 1, 1, 1);
    send_vec(100);
    for (int r = 0; r < N; r++) recv(1, 100, $sformatf("reuse_y%0d", r));

    // Most negative operands everywhere: 4 * 2^26 without overflow.
    for (int i = 0; i < N*N; i++) w_m[i] = -8192;
    set_x(-8192, -8192, -8192, -8192);
    send_mat(100);
    for (int r = 0; r < N; r++) recv(268435456, 100, $sformatf("max_y%0d", r));

    // Negated identity: negative results (clamped when ReLU is built in).
    for (int i = 0; i < N*N; i++) w_m[i] = ((i / N) == (i % N)) ? -1 : 0;
    set_x(5, 5, 5, 5);
    send_mat(100);
    for (int r = 0; r < N; r++) recv(exp_out(-5), 100, $sformatf("neg_y%0d", r));

    // Random packets under random handshake gaps.
    for (int p = 0; p < 20; p++) begin
      bit with_mat = (p == 0) || ($urandom_range(2) != 0);
      for (int i = 0; i < N; i++) x_m[i] = int'($urandom_range(16383)) - 8192;
      if (with_mat) begin
        for (int i = 0; i < N*N; i++) w_m[i] = int'($urandom_range(16383)) - 8192;
        send_mat(50);
      end else begin
        send_vec(50);
      end
      recv_model(30, $sformatf("rnd%0d", p));
    end

    // Reset mid-matrix: partial packet discarded, matrix no longer valid.
    for (int i = 0; i < 7; i++) send_beat(100, (i == 0), 100);
    @(negedge clk);
    input_valid = 1'b0;
    reset = 1'b0;
    #1 check("midrst_in_ready", input_ready, 0);
    check("midrst_out_valid", output_valid, 0);
    check("midrst_out_data", output_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 check("midrst_post_in_ready", input_ready, 1);
    loaded_m = 1'b0;
    set_x(1, 1, 1, 1);
    send_vec(100);
    for (int r = 0; r < N; r++) recv(0, 100, $sformatf("abort_y%0d", r));

    // Fresh full matrix after the aborted one.
    w_m = '{1, 2, 3, 4,  0, -1, 0, 1,  2, 2, 2, 2,  0, 0, 0, 5};
    set_x(1, 2, 3, 4);
    send_mat(100);
    recv(30, 100, "after_y0");
    recv(2, 100, "after_y1");
    recv(20, 100, "after_y2");
    recv(20, 100, "after_y3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matvec_n.md
MATVEC_N -- requirements
Module: matvec_n

Interface
REQ-001 SHALL have parameter N, default 8, meaning matrix dimension (NxN matrix, N-element vector); legal range 2..64.
REQ-002 SHALL have parameter DW, default 14, meaning signed input element width.
REQ-003 SHALL derive localparam OW = 2*DW + $clog2(N), meaning the full-precision signed result width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 input_valid  input  1  input_data beat offered.
REQ-007 input_ready  output  1  block accepts a beat this cycle.
REQ-008 input_data  input  DW  signed matrix or vector element.
REQ-009 new_matrix  input  1  qualifies the first beat of a packet: 1 means matrix follows, 0 means vector only.
REQ-010 output_valid  output  1  output_data holds a result.
REQ-011 output_ready  input  1  consumer accepts result.
REQ-012 output_data  output  OW  signed result element y[r].

Function
REQ-013 A beat SHALL transfer only when input_valid and input_ready are both 1; a result SHALL transfer only when output_valid and output_ready are both 1.
REQ-014 The FSM SHALL have states IDLE, LOAD_W, LOAD_X, COMPUTE and OUTPUT.
REQ-015 In IDLE, input_ready=1; on the first accepted beat, new_matrix=1 SHALL store it as W[0][0] and go to LOAD_W, and new_matrix=0 SHALL store it as x[0] and go to LOAD_X.
REQ-016 new_matrix SHALL be ignored on every beat except the first of a packet.
REQ-017 LOAD_W SHALL accept the remaining N*N-1 matrix elements row-major (W[r][c], c fastest), then go to LOAD_X; matrix_loaded is set on the final W beat.
REQ-018 LOAD_X SHALL accept x[0..N-1] (or the remaining elements), then enter COMPUTE for row 0; input_ready SHALL be 0 in COMPUTE and OUTPUT.
REQ-019 COMPUTE for row r SHALL clear the accumulator, issue N reads of W[r][c]*x[c], register each product (one stage) and accumulate; output_valid SHALL rise exactly N+2 cycles after COMPUTE entry.
REQ-020 Products SHALL be 2*DW signed; accumulation SHALL be in OW bits with no overflow possible.
REQ-021 In OUTPUT, output_data SHALL be held stable while output_valid=1 and output_ready=0.
REQ-022 On transfer of row r<N-1, the block SHALL enter COMPUTE for r+1; on transfer of row N-1, it SHALL return to IDLE.
REQ-023 A vector-only packet SHALL reuse the last loaded matrix.
REQ-024 A vector-only packet while matrix_loaded=0 SHALL produce N results equal to 0.
REQ-025 Gaps in input_valid or output_ready SHALL stall without data loss or duplication.

Reset
REQ-026 Reset asserted (low) SHALL immediately force IDLE, input_ready=0 while asserted, output_valid=0, output_data=0, matrix_loaded=0, counters and accumulator to 0.
REQ-027 Reset mid-packet SHALL discard the partial packet; W/x storage contents need not be cleared.
REQ-028 input_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-029 With macro MATVEC_N_RELU_EN defined, a negative result SHALL be presented as 0 (non-negative results unchanged); without it, output_data SHALL be the raw signed accumulator.

Structure
REQ-030 Package matvec_n_pkg SHALL hold the FSM state typedef and a width function returning 2*DW+$clog2(N).
REQ-031 Sub-module matvec_n_mac SHALL contain the product register and accumulator with clear/enable inputs; the FSM, W memory (N*N x DW) and x register file SHALL reside in matvec_n.

Verification (N=4, DW=14 unless stated)
REQ-032 W=identity, x={1,-2,3,-4}, output_ready=1 -> outputs 1,-2,3,-4 in order; first output_valid 6 cycles after the last x beat enters COMPUTE.
REQ-033 All W=-8192, x all -8192 -> each y = 4*2^26 = 268435456 with no overflow.
REQ-034 A vector-only packet x={1,1,1,1} after the REQ-032 matrix -> 1,1,1,1; the same packet issued first after reset -> 0,0,0,0.
REQ-035 Random input_valid (50%) and output_ready (30%) over 20 packets -> results match the reference model; output_data is stable during stalls; input_ready=0 during COMPUTE/OUTPUT.
REQ-036 Reset pulsed after 7 W beats, then a full matrix packet -> correct results, none from the aborted packet; with MATVEC_N_RELU_EN, W=-identity, x={5,5,5,5} -> 0,0,0,0.
